diag_snapshot_sequencer: RTL and testbench

DIAG_SNAPSHOT_SEQUENCER -- requirements
Module: diag_snapshot_sequencer

---
 rtl/diag_snapshot_sequencer.sv | 101 ++++++++++
 tb/tb_diag_snapshot_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diag_snapshot_sequencer.sv
// diag_snapshot_sequencer: frames an event id plus one A segment and one B segment into a FIRST..LAST packet
// Ports: clk, rst (sync, active-high); ev_valid/ev_id/ev_ready event request;
// a_data/a_type/a_valid/a_rdy and b_data/b_type/b_valid/b_rdy source streams;
// out_data/out_type/out_valid/out_rdy packetizer stream; err sticky timeout flag.
module diag_snapshot_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ev_valid,
   input  logic [15:0]           ev_id,
   output logic                  ev_ready,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic [2:0]            a_type,
   input  logic                  a_valid,
   output logic                  a_rdy,
   input  logic [DATA_WIDTH-1:0] b_data,
   input  logic [2:0]            b_type,
   input  logic                  b_valid,
   output logic                  b_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [2:0]            out_type,
   output logic                  out_valid,
   input  logic                  out_rdy,
   output logic                  err
);
   localparam logic [2:0] T_NONE = 3'd0, T_FIRST = 3'd1, T_MIDDLE = 3'd2, T_LAST = 3'd3, T_SINGLE = 3'd4;
   localparam int TW = $clog2(TIMEOUT + 2);
   typedef enum logic [2:0] {IDLE, HDR, SEG_A, SEG_B, TRL} state_t;
   state_t state_q;
   logic [15:0] id_q, cnt_q;
   logic [TW-1:0] tmo_q;
   logic ta_q, tb_q, err_q;
   logic seg, src_valid, src_none, src_end, src_hs, tmo_hit;
   logic [2:0] src_type;
   logic [DATA_WIDTH-1:0] src_data;
   always_comb begin
      seg = state_q == SEG_A || state_q == SEG_B;
      src_valid = state_q == SEG_A ? a_valid : b_valid;
      src_type = state_q == SEG_A ? a_type : b_type;
      src_data = state_q == SEG_A ? a_data : b_data;
      src_none = src_type == T_NONE;
      // a NONE flit is swallowed without needing the output side
      src_hs = seg && src_valid && (src_none || out_rdy);
      src_end = src_none || src_type == T_SINGLE || src_type == T_LAST;
      tmo_hit = TIMEOUT != 0 && tmo_q == TW'(TIMEOUT);
      ev_ready = state_q == IDLE;
      a_rdy = state_q == SEG_A && (src_none || out_rdy);
      b_rdy = state_q == SEG_B && (src_none || out_rdy);
      out_valid = state_q == HDR || state_q == TRL || (seg && src_valid && !src_none);
      out_type = state_q == HDR ? T_FIRST : state_q == TRL ? T_LAST : (seg && !src_none) ? T_MIDDLE : T_NONE;
      out_data = state_q == HDR ? DATA_WIDTH'(id_q) :
                 state_q == TRL ? DATA_WIDTH'({ta_q, tb_q, 14'd0, cnt_q}) :
                 seg ? src_data : '0;
      err = err_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         id_q <= '0;
         cnt_q <= '0;
         tmo_q <= '0;
         ta_q <= 1'b0;
         tb_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (ev_valid) begin
               state_q <= HDR;
               id_q <= ev_id;
               cnt_q <= '0;
               ta_q <= 1'b0;
               tb_q <= 1'b0;
            end
            HDR: if (out_rdy) begin
               state_q <= SEG_A;
               tmo_q <= '0;
            end
            SEG_A, SEG_B: begin
               if (src_hs) begin
                  tmo_q <= '0;
                  if (!src_none && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                  if (src_end) state_q <= state_q == SEG_A ? SEG_B : TRL;
               end else if (tmo_hit) begin
                  tmo_q <= '0;
                  err_q <= 1'b1;
                  ta_q <= ta_q | (state_q == SEG_A);
                  tb_q <= tb_q | (state_q == SEG_B);
                  state_q <= state_q == SEG_A ? SEG_B : TRL;
               end else if (!src_valid && TIMEOUT != 0) begin
                  // a stalled-but-valid source is backpressure, not idleness
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            TRL: if (out_rdy) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_diag_snapshot_sequencer.sv
// tb_diag_snapshot_sequencer: directed and randomized packets checked against a packet-level model
module tb_diag_snapshot_sequencer;
   localparam int DW = 32;
   localparam int TMO = 8;
   localparam logic [2:0] T_NONE = 3'd0, T_FIRST = 3'd1, T_MID = 3'd2, T_LAST = 3'd3, T_SINGLE = 3'd4;
   typedef struct packed {logic [2:0] t; logic [DW-1:0] d;} flit_t;

   logic clk = 1'b0, rst = 1'b1;
   logic ev_valid = 1'b0, ev_ready;
   logic [15:0] ev_id = '0;
   logic [DW-1:0] a_data = '0, b_data = '0, out_data;
   logic [2:0] a_type = '0, b_type = '0, out_type;
   logic a_valid = 1'b0, b_valid = 1'b0, a_rdy, b_rdy, out_valid, out_rdy = 1'b0, err;

   always #5 clk = ~clk;

   diag_snapshot_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .ev_valid(ev_valid), .ev_id(ev_id), .ev_ready(ev_ready),
      .a_data(a_data), .a_type(a_type), .a_valid(a_valid), .a_rdy(a_rdy),
      .b_data(b_data), .b_type(b_type), .b_valid(b_valid), .b_rdy(b_rdy),
      .out_data(out_data), .out_type(out_type), .out_valid(out_valid), .out_rdy(out_rdy),
      .err(err)
   );

   int tests = 0, fails = 0, cyc = 0, nxfer = 0, hdr_cyc = 0, mid_cyc = 0;
   int rdy_mode = 0, gap_max = 0;
   logic hold_rdy = 1'b0;
   bit in_pkt = 1'b0;
   flit_t qa[$], qb[$], qexp[$], pa[$], pb[$];
   logic [15:0] qev[$];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Packet model: header carries the id, every non-NONE source flit becomes a MIDDLE, trailer counts them.
   function automatic void push_packet(input logic [15:0] id, input bit ta, input bit tb);
      int n = 0;
      qev.push_back(id);
      qexp.push_back('{T_FIRST, DW'(id)});
      foreach (pa[i]) begin
         qa.push_back(pa[i]);
         if (pa[i].t != T_NONE) begin qexp.push_back('{T_MID, pa[i].d}); n++; end
      end
      foreach (pb[i]) begin
         qb.push_back(pb[i]);
         if (pb[i].t != T_NONE) begin qexp.push_back('{T_MID, pb[i].d}); n++; end
      end
      qexp.push_back('{T_LAST, DW'({ta, tb, 14'd0, n > 65535 ? 16'hFFFF : 16'(n)})});
      pa.delete();
      pb.delete();
   endfunction

   function automatic void gen_seg(input bit sel);
      flit_t s[$];
      int k = int'($urandom_range(0, 5));
      if (k == 0) s.push_back('{T_NONE, DW'($urandom)});
      else if (k == 1) s.push_back('{T_SINGLE, DW'($urandom)});
      else begin
         s.push_back('{T_FIRST, DW'($urandom)});
         for (int i = 0; i < k - 2; i++) s.push_back('{T_MID, DW'($urandom)});
         s.push_back('{T_LAST, DW'($urandom)});
      end
      if (sel) pb = s; else pa = s;
   endfunction

   // Input driver: streams the queues with random gaps, holds data until accepted.
   initial begin : drv
      bit ha, hb, he;
      int ga = 0, gb = 0, ge = 0;
      forever begin
         @(negedge clk);
         ha = a_valid && a_rdy;
         hb = b_valid && b_rdy;
         he = ev_valid && ev_ready;
         @(posedge clk);
         #1;
         out_rdy = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~out_rdy :
                   rdy_mode == 2 ? ($urandom_range(0, 3) != 0) : hold_rdy;
         if (rst) begin
            qa.delete(); qb.delete(); qev.delete();
            a_valid = 1'b0; b_valid = 1'b0; ev_valid = 1'b0;
            ga = 0; gb = 0; ge = 0;
         end else begin
            if (ha) begin void'(qa.pop_front()); ga = int'($urandom_range(0, gap_max)); end
            if (hb) begin void'(qb.pop_front()); gb = int'($urandom_range(0, gap_max)); end
            if (he) begin void'(qev.pop_front()); ge = int'($urandom_range(0, gap_max)); end
            if (ga > 0) begin a_valid = 1'b0; ga--; end
            else if (qa.size() > 0) begin a_valid = 1'b1; a_type = qa[0].t; a_data = qa[0].d; end
            else a_valid = 1'b0;
            if (gb > 0) begin b_valid = 1'b0; gb--; end
            else if (qb.size() > 0) begin b_valid = 1'b1; b_type = qb[0].t; b_data = qb[0].d; end
            else b_valid = 1'b0;
            if (ge > 0) begin ev_valid = 1'b0; ge--; end
            else if (qev.size() > 0) begin ev_valid = 1'b1; ev_id = qev[0]; end
            else ev_valid = 1'b0;
         end
      end
   end

   // Compare process: every output transfer against the model, plus per-cycle handshake rules.
   initial begin : cmp
      flit_t e, prev;
      bit stall = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            qexp.delete();
            in_pkt = 1'b0;
            stall = 1'b0;
            continue;
         end
         if (!in_pkt) begin
            chk("idle_ev_ready", ev_ready, 1);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_out_type", out_type, T_NONE);
            chk("idle_a_rdy", a_rdy, 0);
            chk("idle_b_rdy", b_rdy, 0);
         end else chk("busy_ev_ready", ev_ready, 0);
         chk("rdy_exclusive", a_rdy & b_rdy, 0);
         if (stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_type", out_type, prev.t);
            chk("hold_data", out_data, prev.d);
         end
         if (out_valid && out_rdy) begin
            nxfer++;
            if (qexp.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_flit: got type %0d data %h, expected no flit", out_type, out_data);
            end else begin
               e = qexp.pop_front();
               chk("flit_type", out_type, e.t);
               chk("flit_data", out_data, e.d);
               if (e.t == T_FIRST) hdr_cyc = cyc;
               if (e.t == T_MID) mid_cyc = cyc;
               if (e.t == T_LAST) in_pkt = 1'b0;
            end
         end
         if (ev_valid && ev_ready) in_pkt = 1'b1;
         stall = out_valid && !out_rdy;
         prev = '{out_type, out_data};
      end
   end

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while ((qexp.size() != 0 || qev.size() != 0) && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({name, "_pending"}, qexp.size(), 0);
      repeat (2) @(negedge clk);
      #1;
   endtask

   initial begin : wdog
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin : main
      int n0, n;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      #1;
      chk("reset_err", err, 0);
      chk("reset_ev_ready", ev_ready, 1);
      chk("reset_out_valid", out_valid, 0);

      // single A flit, empty B
      rdy_mode = 0;
      gap_max = 0;
      pa.push_back('{T_SINGLE, 32'hAA});
      pb.push_back('{T_NONE, 32'h0});
      push_packet(16'h1234, 1'b0, 1'b0);
      chk("model_len", qexp.size(), 3);
      chk("model_hdr", qexp[0].d, 32'h1234);
      chk("model_mid", qexp[1].d, 32'hAA);
      chk("model_trl", qexp[2].d, 32'h1);
      n0 = nxfer;
      wait_done("req028", 60);
      chk("req028_flits", nxfer - n0, 3);

      // multi-flit segments with toggling ready
      rdy_mode = 1;
      pa.push_back('{T_FIRST, 32'h11111111});
      pa.push_back('{T_MID, 32'h22222222});
      pa.push_back('{T_LAST, 32'h33333333});
      pb.push_back('{T_FIRST, 32'h44444444});
      pb.push_back('{T_LAST, 32'h55555555});
      push_packet(16'h0029, 1'b0, 1'b0);
      chk("model_cnt5", qexp[6].d, 32'd5);
      n0 = nxfer;
      wait_done("req029", 100);
      chk("req029_flits", nxfer - n0, 7);
      chk("req029_err", err, 0);

      // A never valid: segment A times out, B still forwarded
      rdy_mode = 0;
      pb.push_back('{T_SINGLE, 32'hBEEF});
      push_packet(16'h0030, 1'b1, 1'b0);
      chk("model_tmo_trl", qexp[2].d, 32'h80000001);
      wait_done("req030", 100);
      chk("req030_err", err, 1);
      chk("req030_gap", mid_cyc - hdr_cyc, TMO + 2);

      // back-to-back events: second id waits for the first trailer, err persists
      rdy_mode = 2;
      gen_seg(0); gen_seg(1); push_packet(16'hA001, 1'b0, 1'b0);
      gen_seg(0); gen_seg(1); push_packet(16'hA002, 1'b0, 1'b0);
      wait_done("req031", 200);
      chk("req031_err", err, 1);

      // randomized traffic, idle gaps kept below the timeout
      gap_max = 3;
      for (int i = 0; i < 40; i++) begin
         gen_seg(0);
         gen_seg(1);
         push_packet(16'($urandom), 1'b0, 1'b0);
      end
      wait_done("random", 6000);

      // reset in the middle of segment B
      rdy_mode = 0;
      gap_max = 0;
      pa.push_back('{T_SINGLE, 32'h0A0A});
      for (int i = 0; i < 5; i++) pb.push_back('{i == 0 ? T_FIRST : i == 4 ? T_LAST : T_MID, DW'(32'hB0 + i)});
      push_packet(16'h0032, 1'b0, 1'b0);
      n0 = nxfer;
      n = 0;
      while (nxfer - n0 < 3 && n < 50) begin @(negedge clk); #1; n++; end
      chk("req032_reach_segb", nxfer - n0 >= 3, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      #1;
      chk("req032_out_valid", out_valid, 0);
      chk("req032_err", err, 0);
      chk("req032_ev_ready", ev_ready, 1);
      n0 = nxfer;
      repeat (20) @(negedge clk);
      #1;
      chk("req032_no_trailer", nxfer - n0, 0);

      // long backpressure on a valid A flit is not a timeout
      rdy_mode = 3;
      hold_rdy = 1'b0;
      pa.push_back('{T_SINGLE, 32'h33});
      pb.push_back('{T_NONE, 32'h0});
      push_packet(16'h0033, 1'b0, 1'b0);
      n = 0;
      while (!(out_valid && out_type == T_FIRST) && n < 50) begin @(negedge clk); #1; n++; end
      chk("req033_hdr_seen", out_valid && out_type == T_FIRST, 1);
      @(posedge clk);
      #2 hold_rdy = 1'b1;
      @(posedge clk);
      #2 hold_rdy = 1'b0;
      repeat (300) @(negedge clk);
      #1;
      chk("req033_stall_valid", out_valid, 1);
      chk("req033_stall_type", out_type, T_MID);
      chk("req033_stall_data", out_data, 32'h33);
      hold_rdy = 1'b1;
      wait_done("req033", 60);
      chk("req033_err", err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
